shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin write arbiter and storage for a small bank of shared configuration/state registers used by the compression and decompression engines. Up to NUM_REQ requesters issue single-cycle write requests (address + data). The block grants at most one per cycle, commits the winner's data into the bank, and exposes a combinational read port. An optional lock lets one requester hold the bank for multi-cycle atomic update sequences.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- BIT_WIDTH, 32: register data width
- NUM_REGS, 8: registers in the bank (≤ 2^ADDR_WIDTH)
- ADDR_WIDTH, 3: write/read address width
- RESET_VALUE, 0: value loaded into every bank register on reset
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester write request
- lock  in  NUM_REQ  per-requester lock request, sampled only for the granted requester
- wrAddr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wrData  in  NUM_REQ*BIT_WIDTH  packed data, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
- grant  out  NUM_REQ  one-hot or zero, combinational, same cycle as req
- locked  out  1  registered, 1 while in LOCKED state
- rdAddr  in  ADDR_WIDTH  read address
- rdData  out  BIT_WIDTH  combinational bank[rdAddr]; 0 if rdAddr ≥ NUM_REGS
- errCount  out  8  registered, saturating count of dropped out-of-range writes

## Operation
- States: IDLE, LOCKED (owner index held in a register).
- IDLE: grant goes to the first requester with req=1 searching from ptr upward, wrapping modulo NUM_REQ. No req → grant=0.
- On an edge with grant[i]=1: bank[wrAddr_i] ← wrData_i; ptr ← (i+1) mod NUM_REQ. If lock[i]=1 as well → LOCKED, owner ← i.
- LOCKED: grant[owner]=req[owner]; all other grants 0 regardless of ptr. At an edge where lock[owner]=0 → IDLE, ptr ← (owner+1) mod NUM_REQ. A write granted in that same cycle still commits.
- LOCKED with req[owner]=0 and lock[owner]=1: bank is held idle, no grant.
- Out-of-range wrAddr (≥ NUM_REGS) when granted: grant still issued and lock/ptr update normally; no register changes; errCount increments, saturating at 255.
- Reset (any cycle, including mid-lock): state IDLE, ptr=0, owner=0, all bank registers = RESET_VALUE, errCount=0, locked=0. grant=0 while reset=1.

## Timing
- Grant latency 0 cycles (combinational). Write visible on rdData the cycle after the granting edge.
- Read-during-write to the same address returns the old value.
- Throughput: one write per cycle. Fairness: with all requesters continuously requesting and no lock, each is granted once every NUM_REQ cycles.
- locked and errCount change only on clock edges.

## Structure
- Shared package: ST_IDLE/ST_LOCKED state encoding, errCount width (8), the saturation limit.
- One natural sub-module: rr_pick, a combinational round-robin priority picker. Inputs are req and ptr; outputs are a one-hot grant and its index. It is reusable by other arbiters in the design.
- The bank is NUM_REGS write-enabled registers with reset value RESET_VALUE.

## Test plan
- Reset then idle: rdData=0 at all addresses, grant=0, locked=0, errCount=0.
- req=4'b1111 for 8 cycles, addr_i=i, data_i=0x10+i, ptr=0 → grant sequence 0001,0010,0100,1000, repeated; bank[0..3]=0x10..0x13.
- Requester 1 sends req+lock for 3 cycles while req=4'b1111 → grant=0010 for 3 cycles, locked=1. Requester 1 then drops lock on its 3rd write → next grant is 0100, locked=0.
- Write to addr 7 with NUM_REGS=6 → grant issued, errCount=1, bank unchanged. Repeat 300 times → errCount holds at 255.
- rdAddr=2 and a granted write to addr 2 (0xAA→0x55) in the same cycle → rdData=0xAA that cycle, 0x55 the next.
- Reset asserted while LOCKED with owner 3 → next cycle locked=0, grant follows ptr=0, bank = RESET_VALUE.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and limits for the register-bank arbiter
package shared_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_SAT = 8'hFF;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational round-robin picker
// Grants the first set request at or above ptr, wrapping around.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  logic w_found;

  // Outer loop walks priority order; inner loop keeps every select index constant.
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && req[j] && (j == (int'(ptr) + k) % NUM_REQ)) begin
          w_found  = 1'b1;
          grant[j] = 1'b1;
          idx      = PTR_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write arbiter with lockable shared register bank
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BIT_WIDTH  = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wrAddr,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   wrData,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           locked,
  input  logic [ADDR_WIDTH-1:0]          rdAddr,
  output logic [BIT_WIDTH-1:0]           rdData,
  output logic [ERR_W-1:0]               errCount
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]      r_owner, w_owner_nxt;
  logic [ERR_W-1:0]      r_err;
  logic [BIT_WIDTH-1:0]  r_bank [NUM_REGS];

  logic [NUM_REQ-1:0]    w_pick_grant;
  logic [PTR_W-1:0]      w_pick_idx;
  logic                  w_win;
  logic [PTR_W-1:0]      w_win_idx;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [BIT_WIDTH-1:0]  w_win_data;
  logic                  w_in_range;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_pick_grant),
    .idx   (w_pick_idx)
  );

  always_comb begin
    grant       = '0;
    w_win       = 1'b0;
    w_win_idx   = '0;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (!reset) begin
      if (r_state == ST_IDLE) begin
        grant     = w_pick_grant;
        w_win     = |req;
        w_win_idx = w_pick_idx;
        if (w_win) begin
          w_ptr_nxt = f_inc(w_pick_idx);
          if (lock[w_pick_idx]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_pick_idx;
          end
        end
      end else begin
        // Owner keeps exclusive access; releasing lock hands priority to its neighbour.
        grant[r_owner] = req[r_owner];
        w_win          = req[r_owner];
        w_win_idx      = r_owner;
        if (w_win) w_ptr_nxt = f_inc(r_owner);
        if (!lock[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = f_inc(r_owner);
        end
      end
    end
  end

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == w_win_idx) begin
        w_win_addr = wrAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = wrData[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
    w_in_range = int'(w_win_addr) < NUM_REGS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_err   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= RESET_VALUE;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      if (w_win) begin
        if (w_in_range) r_bank[w_win_addr] <= w_win_data;
        else if (r_err != ERR_SAT) r_err <= r_err + 1'b1;
      end
    end
  end

  always_comb begin
    rdData = '0;
    if (int'(rdAddr) < NUM_REGS) rdData = r_bank[rdAddr];
  end

  assign locked   = (r_state == ST_LOCKED);
  assign errCount = r_err;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam logic [BW-1:0] RV = 32'hA5A5_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, lock, grant;
  logic [N*AW-1:0]   wrAddr;
  logic [N*BW-1:0]   wrData;
  logic              locked;
  logic [AW-1:0]     rdAddr;
  logic [BW-1:0]     rdData;
  logic [7:0]        errCount;

  always #5 clk = ~clk;

  shared_reg_arbiter #(
    .NUM_REQ(N), .BIT_WIDTH(BW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wrAddr(wrAddr), .wrData(wrData),
    .grant(grant), .locked(locked), .rdAddr(rdAddr), .rdData(rdData), .errCount(errCount)
  );

  typedef struct {
    bit           chk;
    logic [N-1:0] grant;
    logic [BW-1:0] rd;
    logic         locked;
    int           err;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_locked;
  int            m_owner, m_ptr, m_err;
  logic [BW-1:0] m_bank [NR];

  int            st_addr [N];
  logic [BW-1:0] st_data [N];

  function automatic int model_winner(input logic [N-1:0] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] l,
                      input int ra, input bit chk);
    exp_t e;
    int   w;
    reset = rst;
    req   = r;
    lock  = l;
    for (int i = 0; i < N; i++) begin
      wrAddr[i*AW +: AW] = AW'(st_addr[i]);
      wrData[i*BW +: BW] = st_data[i];
    end
    rdAddr = AW'(ra);
    w = rst ? -1 : model_winner(r);
    e.chk    = chk;
    e.grant  = '0;
    if (w >= 0) e.grant[w] = 1'b1;
    e.rd     = (ra < NR) ? m_bank[ra] : '0;
    e.locked = m_locked;
    e.err    = m_err;
    sb.push_back(e);
    if (rst) begin
      m_locked = 0; m_ptr = 0; m_owner = 0; m_err = 0;
      for (int i = 0; i < NR; i++) m_bank[i] = RV;
    end else begin
      if (w >= 0) begin
        if (st_addr[w] < NR) m_bank[st_addr[w]] = st_data[w];
        else if (m_err < 255) m_err = m_err + 1;
        m_ptr = (w + 1) % N;
      end
      if (m_locked) begin
        if (!l[m_owner]) begin
          m_locked = 0;
          m_ptr    = (m_owner + 1) % N;
        end
      end else if (w >= 0 && l[w]) begin
        m_locked = 1;
        m_owner  = w;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk) begin
        compare("grant", 64'(grant), 64'(e.grant));
        compare("rdData", 64'(rdData), 64'(e.rd));
        compare("locked", 64'(locked), 64'(e.locked));
        compare("errCount", 64'(errCount), 64'(e.err));
      end
    end
  end

  task automatic set_lanes(input int a, input int dbase);
    for (int i = 0; i < N; i++) begin
      st_addr[i] = (a < 0) ? i : a;
      st_data[i] = BW'(dbase + i);
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; wrAddr = '0; wrData = '0; rdAddr = '0;
    set_lanes(0, 0);
    @(posedge clk);
    #1;
    step(1, '0, '0, 0, 0);
    step(1, '0, '0, 0, 1);
    for (int a = 0; a < 8; a++) step(0, '0, '0, a, 1);

    // all requesters, no lock: strict rotation
    set_lanes(-1, 'h10);
    for (int c = 0; c < 8; c++) step(0, 4'b1111, '0, c % 4, 1);
    for (int a = 0; a < 8; a++) step(0, '0, '0, a, 1);

    // requester 1 locks, idles while holding, then releases on its third write
    set_lanes(-1, 'h20);
    step(0, 4'b0001, '0, 0, 1);
    step(0, 4'b1111, 4'b0010, 1, 1);
    step(0, 4'b1101, 4'b0010, 1, 1);
    step(0, 4'b1111, 4'b0010, 2, 1);
    step(0, 4'b1111, 4'b0000, 1, 1);
    step(0, 4'b1111, 4'b0000, 2, 1);

    // out-of-range writes saturate the error counter
    for (int c = 0; c < 300; c++) begin
      set_lanes(7, int'($urandom));
      step(0, N'($urandom_range(1, 15)), '0, int'($urandom_range(0, 7)), 1);
    end

    // read-during-write returns the old value
    set_lanes(2, 0);
    st_data[0] = 'hAA;
    step(0, 4'b0001, '0, 2, 1);
    st_data[0] = 'h55;
    step(0, 4'b0001, '0, 2, 1);
    step(0, '0, '0, 2, 1);

    // reset while owner 3 holds the lock
    set_lanes(-1, 'h40);
    step(0, 4'b1000, 4'b1000, 3, 1);
    step(0, 4'b1111, 4'b1000, 3, 1);
    step(1, 4'b1111, 4'b1111, 3, 1);
    step(0, 4'b1111, '0, 3, 1);
    for (int a = 0; a < 8; a++) step(0, '0, '0, a, 1);

    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        st_addr[i] = int'($urandom_range(0, 7));
        st_data[i] = $urandom;
      end
      step(($urandom_range(0, 63) == 0), N'($urandom), N'($urandom & $urandom),
           int'($urandom_range(0, 7)), 1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
